kth_largest_tracker: RTL and testbench

//   Streaming order-statistic tracker that keeps the K largest samples seen since reset or clear.
//   It maintains a sorted register file and reports the K-th largest value once K samples have arrived.
//   It generalises the second-largest tracker to any depth K, with a valid qualifier, a synchronous clear
//   and signed/unsigned compare. It sits on a sample stream in front of threshold and statistics logic.

---
 rtl/kth_largest_tracker.sv | 78 +++++++
 tb/tb_kth_largest_tracker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/kth_largest_tracker.sv
// Streaming top-K tracker: keeps the K largest samples since reset/clear in a sorted
// register file, updated by a single-cycle parallel compare-and-shift.
module kth_largest_tracker #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 2,
  parameter bit SIGNED     = 1'b0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    din_valid,
  input  logic                    clear,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_valid,
  output logic [DATA_WIDTH-1:0]   max_out,
  output logic [$clog2(K+1)-1:0]  count,
  output logic [K*DATA_WIDTH-1:0] topk
);

  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0] FULL = CW'(K);

  logic [DATA_WIDTH-1:0] top_q [K];
  logic [DATA_WIDTH-1:0] base  [K];
  logic [DATA_WIDTH-1:0] top_d [K];
  logic [CW-1:0]         cnt_q, base_cnt, cnt_d;
  logic [K-1:0]          ins;

  function automatic logic greater(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    if (SIGNED) return $signed(a) > $signed(b);
    else        return a > b;
  endfunction

  // Clear is folded in ahead of insertion so clear+din_valid leaves din alone in slot 0.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that skips an assignment infers a latch.
    base_cnt = clear ? '0 : cnt_q;
    for (int i = 0; i < K; i++) begin
      base[i] = clear ? '0 : top_q[i];
      ins[i]  = (CW'(i) >= base_cnt) || greater(din, base[i]);
    end

    // ins[] is monotonic over a sorted list, so slot i takes din at the first set bit
    // and its upper neighbour for every set bit after it.
    top_d[0] = (din_valid && ins[0]) ? din : base[0];
    for (int i = 1; i < K; i++) begin
      top_d[i] = base[i];
      if (din_valid && ins[i])
        top_d[i] = ins[i-1] ? base[i-1] : din;
    end

    cnt_d = base_cnt;
    if (din_valid && base_cnt != FULL)
      cnt_d = base_cnt + 1'b1;
  end

  // NOTE: the register file is small and must read 0 after reset, so every slot is reset explicitly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < K; i++) top_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every slot's next value based on the pre-edge state.
      for (int i = 0; i < K; i++) top_q[i] <= top_d[i];
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    count      = cnt_q;
    dout_valid = (cnt_q == FULL);
    dout       = dout_valid ? top_q[K-1] : '0;
    max_out    = (cnt_q != '0) ? top_q[0] : '0;
    for (int i = 0; i < K; i++)
      topk[i*DATA_WIDTH +: DATA_WIDTH] = (CW'(i) < cnt_q) ? top_q[i] : '0;
  end

endmodule

// File: tb/tb_kth_largest_tracker.sv
// Self-checking bench: five tracker configurations on one shared stream, checked against
// a queue-based sorted reference model plus directed expectations.
module tb_kth_largest_tracker;

  localparam int DW = 32;
  typedef logic [DW-1:0] q_t[$];

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          clear = 1'b0;

  always #5 clk = ~clk;

  logic [DW-1:0]   dout_1, dout_2, dout_4, dout_5, dout_s;
  logic            dv_1, dv_2, dv_4, dv_5, dv_s;
  logic [DW-1:0]   max_1, max_2, max_4, max_5, max_s;
  logic [0:0]      count_1;
  logic [1:0]      count_2, count_s;
  logic [2:0]      count_4, count_5;
  logic [1*DW-1:0] topk_1;
  logic [2*DW-1:0] topk_2, topk_s;
  logic [4*DW-1:0] topk_4;
  logic [5*DW-1:0] topk_5;

  kth_largest_tracker #(.DATA_WIDTH(DW), .K(1), .SIGNED(1'b0)) u_k1 (
    .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .clear(clear),
    .dout(dout_1), .dout_valid(dv_1), .max_out(max_1), .count(count_1), .topk(topk_1));
  kth_largest_tracker #(.DATA_WIDTH(DW), .K(2), .SIGNED(1'b0)) u_k2 (
    .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .clear(clear),
    .dout(dout_2), .dout_valid(dv_2), .max_out(max_2), .count(count_2), .topk(topk_2));
  kth_largest_tracker #(.DATA_WIDTH(DW), .K(4), .SIGNED(1'b0)) u_k4 (
    .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .clear(clear),
    .dout(dout_4), .dout_valid(dv_4), .max_out(max_4), .count(count_4), .topk(topk_4));
  kth_largest_tracker #(.DATA_WIDTH(DW), .K(5), .SIGNED(1'b0)) u_k5 (
    .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .clear(clear),
    .dout(dout_5), .dout_valid(dv_5), .max_out(max_5), .count(count_5), .topk(topk_5));
  kth_largest_tracker #(.DATA_WIDTH(DW), .K(2), .SIGNED(1'b1)) u_s2 (
    .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .clear(clear),
    .dout(dout_s), .dout_valid(dv_s), .max_out(max_s), .count(count_s), .topk(topk_s));

  int n_cmp = 0;
  int n_err = 0;
  q_t q1, q2, q4, q5, qs;

  task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: sorted list, new sample goes after any equal entries, list truncated to k.
  function automatic q_t model_ins(input q_t q, input int k, input bit sgn, input logic [DW-1:0] d);
    int pos = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (sgn ? ($signed(d) > $signed(q[i])) : (d > q[i])) begin
        pos = i;
        break;
      end
    end
    q.insert(pos, d);
    if (q.size() > k) void'(q.pop_back());
    return q;
  endfunction

  function automatic logic [159:0] pack(input q_t q);
    logic [159:0] v = '0;
    for (int i = 0; i < q.size(); i++) v[i*DW +: DW] = q[i];
    return v;
  endfunction

  task automatic model_clear();
    q1.delete(); q2.delete(); q4.delete(); q5.delete(); qs.delete();
  endtask

  task automatic check_inst(input string tag, input int k, input q_t q, input logic [159:0] tk,
                            input int cnt, input logic [DW-1:0] dout_a, input logic dv_a,
                            input logic [DW-1:0] max_a);
    logic [DW-1:0] exp_dout = (q.size() == k) ? q[k-1] : '0;
    logic [DW-1:0] exp_max  = (q.size() > 0) ? q[0] : '0;
    check({tag, ".count"}, 160'(cnt), 160'(q.size()));
    check({tag, ".dout"}, 160'(dout_a), 160'(exp_dout));
    check({tag, ".dout_valid"}, 160'(dv_a), 160'(q.size() == k));
    check({tag, ".max_out"}, 160'(max_a), 160'(exp_max));
    check({tag, ".topk"}, tk, pack(q));
  endtask

  task automatic check_all(input string tag);
    check_inst({tag, ".k1"}, 1, q1, 160'(topk_1), int'(count_1), dout_1, dv_1, max_1);
    check_inst({tag, ".k2"}, 2, q2, 160'(topk_2), int'(count_2), dout_2, dv_2, max_2);
    check_inst({tag, ".k4"}, 4, q4, 160'(topk_4), int'(count_4), dout_4, dv_4, max_4);
    check_inst({tag, ".k5"}, 5, q5, 160'(topk_5), int'(count_5), dout_5, dv_5, max_5);
    check_inst({tag, ".s2"}, 2, qs, 160'(topk_s), int'(count_s), dout_s, dv_s, max_s);
  endtask

  // Called at a negedge: drive, take the rising edge, update the model, check at the next negedge.
  task automatic step(input string tag, input logic [DW-1:0] d, input logic v, input logic c);
    din = d; din_valid = v; clear = c;
    @(posedge clk);
    if (c) model_clear();
    if (v) begin
      q1 = model_ins(q1, 1, 1'b0, d);
      q2 = model_ins(q2, 2, 1'b0, d);
      q4 = model_ins(q4, 4, 1'b0, d);
      q5 = model_ins(q5, 5, 1'b0, d);
      qs = model_ins(qs, 2, 1'b1, d);
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [DW-1:0] t1_in   [4] = '{32'd5, 32'd9, 32'd3, 32'd7};
    logic [DW-1:0] t1_dout [4] = '{32'd0, 32'd5, 32'd5, 32'd7};
    logic [DW-1:0] t1_max  [4] = '{32'd5, 32'd9, 32'd9, 32'd9};
    logic [DW-1:0] t2_in   [5] = '{32'd10, 32'd40, 32'd20, 32'd30, 32'd25};
    logic [DW-1:0] vals [20];
    q_t snap;

    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1 check_all("reset");
    @(negedge clk);

    // T1
    for (int i = 0; i < 4; i++) begin
      step("t1", t1_in[i], 1'b1, 1'b0);
      check("t1.dout", 160'(dout_2), 160'(t1_dout[i]));
      check("t1.dout_valid", 160'(dv_2), 160'(i > 0));
      check("t1.max_out", 160'(max_2), 160'(t1_max[i]));
    end

    // T2
    step("t2", t2_in[0], 1'b1, 1'b1);
    for (int i = 1; i < 5; i++) begin
      step("t2", t2_in[i], 1'b1, 1'b0);
      if (i == 3) begin
        check("t2.topk4", 160'(topk_4), {32'd10, 32'd20, 32'd30, 32'd40});
        check("t2.dout4", 160'(dout_4), 160'd10);
      end
    end
    check("t2.topk5", 160'(topk_4), {32'd20, 32'd25, 32'd30, 32'd40});
    check("t2.dout5", 160'(dout_4), 160'd20);

    // T3 ties
    step("t3", 32'd8, 1'b1, 1'b1);
    step("t3", 32'd8, 1'b1, 1'b0);
    step("t3", 32'd8, 1'b1, 1'b0);
    check("t3.topk", 160'(topk_2), {32'd8, 32'd8});
    check("t3.count", 160'(count_2), 160'd2);
    step("t3", 32'd1, 1'b1, 1'b0);
    check("t3.hold", 160'(topk_2), {32'd8, 32'd8});

    // T4 signed vs unsigned
    step("t4", 32'hFFFF_FFFD, 1'b1, 1'b1);
    step("t4", 32'hFFFF_FFF9, 1'b1, 1'b0);
    check("t4.sdout", 160'(dout_s), 160'(32'hFFFF_FFF9));
    step("t4", 32'd2, 1'b1, 1'b0);
    check("t4.stopk", 160'(topk_s), {32'hFFFF_FFFD, 32'd2});
    check("t4.umax", 160'(max_2), 160'(32'hFFFF_FFFD));

    // T5 clear
    step("t5", 32'd9, 1'b1, 1'b1);
    step("t5", 32'd5, 1'b1, 1'b0);
    check("t5.held", 160'(topk_2), {32'd5, 32'd9});
    step("t5", 32'd77, 1'b0, 1'b1);
    check("t5.count", 160'(count_2), 160'd0);
    check("t5.dv", 160'(dv_2), 160'd0);
    step("t5", 32'd4, 1'b1, 1'b1);
    check("t5.count1", 160'(count_2), 160'd1);
    check("t5.max", 160'(max_2), 160'd4);

    // T6 asynchronous reset between edges
    step("t6", 32'd13, 1'b1, 1'b0);
    din_valid = 1'b0;
    #2 resetn = 1'b0;
    #1 model_clear();
    check_all("t6.async");
    @(negedge clk);
    resetn = 1'b1;
    step("t6", 32'd6, 1'b1, 1'b0);
    step("t6", 32'd2, 1'b1, 1'b0);
    check("t6.dout", 160'(dout_2), 160'd2);

    // Gapped stream must end in the same state as the back-to-back stream
    for (int i = 0; i < 20; i++) vals[i] = $urandom_range(0, 31);
    step("b2b", vals[0], 1'b1, 1'b1);
    for (int i = 1; i < 20; i++) step("b2b", vals[i], 1'b1, 1'b0);
    snap = q5;
    step("gap", vals[0], 1'b1, 1'b1);
    for (int i = 1; i < 20; i++) begin
      step("gap", $urandom, 1'b0, 1'b0);
      step("gap", $urandom, 1'b0, 1'b0);
      step("gap", vals[i], 1'b1, 1'b0);
    end
    check("gap.k5", 160'(topk_5), pack(snap));

    // Random stream with ties, wide values, gaps and occasional clears
    for (int i = 0; i < 800; i++) begin
      logic [DW-1:0] d = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom);
      step("rand", d, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
